// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state type and sizing helpers for conv2d_stream_engine
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, HOLD} state_t;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int out_size(input int img, input int ker, input int pad);
        return img + 2 * pad - ker + 1;
    endfunction

    function automatic int acc_width(input int dw, input int ker);
        return 2 * dw + clog2(ker * ker);
    endfunction

endpackage

// File: rtl/conv2d_stream_engine_if.sv
// conv2d_stream_engine_if: control, load streams and output stream of the conv engine
interface conv2d_stream_engine_if #(
    parameter int DW = 16
);
    logic                 start;
    logic                 flip;
    logic                 img_valid;
    logic                 img_ready;
    logic signed [DW-1:0] img_data;
    logic                 ker_valid;
    logic                 ker_ready;
    logic signed [DW-1:0] ker_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_last;
    logic                 busy;
    logic                 done;

    modport master (
        output start, flip, img_valid, img_data, ker_valid, ker_data, out_ready,
        input  img_ready, ker_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  start, flip, img_valid, img_data, ker_valid, ker_data, out_ready,
        output img_ready, ker_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/conv_mac.sv
// conv_mac: signed MAC with sync clear/enable and shift + wrap/saturate output stage.
// CONV_SAT_EN selects saturation to the signed DW range; otherwise the result wraps.
module conv_mac #(
    parameter int DW   = 16,
    parameter int AW   = 36,
    parameter int FRAC = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [DW-1:0] b_i,
    output logic signed [DW-1:0] y_o
);
    logic signed [AW-1:0] acc_q, acc_d;

    always_comb acc_d = clr_i ? '0 : en_i ? acc_q + AW'(a_i) * AW'(b_i) : acc_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc_q <= '0;
        else acc_q <= acc_d;

`ifdef CONV_SAT_EN
    localparam logic signed [AW-1:0] MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [AW-1:0] sh;
    always_comb begin
        sh  = acc_q >>> FRAC;
        y_o = sh > MAX ? MAX[DW-1:0] : sh < MIN ? MIN[DW-1:0] : sh[DW-1:0];
    end
`else
    always_comb y_o = DW'(acc_q >>> FRAC);
`endif
endmodule

// File: rtl/conv2d_stream_engine.sv
// conv2d_stream_engine: streamed IMGxIMG by KERxKER correlation/convolution with implicit zero padding.
// Output stage wraps by default; define CONV_SAT_EN to saturate instead.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int DW   = 16,
    parameter int IMG  = 16,
    parameter int KER  = 3,
    parameter int PAD  = 1,
    parameter int FRAC = 0
) (
    input logic clk,
    input logic rst_n,
    conv2d_stream_engine_if.slave bus
);
    localparam int OUT = out_size(IMG, KER, PAD);
    localparam int AW  = acc_width(DW, KER);
    localparam int NI  = IMG * IMG;
    localparam int NK  = KER * KER;
    localparam int IW  = clog2(NI + 1);
    localparam int KW  = clog2(NK + 1);
    localparam int IA  = clog2(NI);
    localparam int KA  = clog2(NK);
    localparam int CW  = clog2(KER + 1);
    localparam int OW  = clog2(OUT + 1);
    localparam logic [IW-1:0] NI_L = IW'(NI);
    localparam logic [KW-1:0] NK_L = KW'(NK);
    localparam logic [CW-1:0] K_L  = CW'(KER - 1);
    localparam logic [OW-1:0] O_L  = OW'(OUT - 1);

    if (KER > IMG + 2 * PAD) begin : g_bad_ker
        $error("conv2d_stream_engine: KER exceeds padded image size");
    end

    state_t               state_q, state_d;
    logic [IW-1:0]        img_cnt_q, img_cnt_d;
    logic [KW-1:0]        ker_cnt_q, ker_cnt_d;
    logic [CW-1:0]        i_q, i_d, j_q, j_d;
    logic [OW-1:0]        r_q, r_d, c_q, c_d;
    logic                 flip_q, flip_d, done_q, done_d, clr, en;
    logic                 img_hs, ker_hs, out_hs, last;
    logic signed [DW-1:0] img_mem [NI];
    logic signed [DW-1:0] ker_mem [NK];
    logic signed [DW-1:0] pix, kv, y;
    int                   pr, pc, ki, kj;

    assign bus.img_ready = state_q == LOAD && img_cnt_q != NI_L;
    assign bus.ker_ready = state_q == LOAD && ker_cnt_q != NK_L;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_data  = y;
    assign bus.out_last  = bus.out_valid && last;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;
    assign img_hs = bus.img_valid && bus.img_ready;
    assign ker_hs = bus.ker_valid && bus.ker_ready;
    assign out_hs = bus.out_valid && bus.out_ready;
    assign last   = r_q == O_L && c_q == O_L;

    always_ff @(posedge clk) begin
        if (img_hs) img_mem[IA'(img_cnt_q)] <= bus.img_data;
        if (ker_hs) ker_mem[KA'(ker_cnt_q)] <= bus.ker_data;
    end

    // Padding is implicit: out-of-image taps read as zero instead of stored border.
    always_comb begin
        pr  = int'(r_q) + int'(i_q) - PAD;
        pc  = int'(c_q) + int'(j_q) - PAD;
        ki  = flip_q ? KER - 1 - int'(i_q) : int'(i_q);
        kj  = flip_q ? KER - 1 - int'(j_q) : int'(j_q);
        pix = (pr >= 0 && pr < IMG && pc >= 0 && pc < IMG) ? img_mem[IA'(pr * IMG + pc)] : '0;
        kv  = ker_mem[KA'(ki * KER + kj)];
    end

    always_comb begin
        state_d   = state_q;
        img_cnt_d = img_cnt_q;
        ker_cnt_d = ker_cnt_q;
        i_d       = i_q;
        j_d       = j_q;
        r_d       = r_q;
        c_d       = c_q;
        flip_d    = flip_q;
        done_d    = 1'b0;
        clr       = 1'b0;
        en        = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                flip_d    = bus.flip;
                img_cnt_d = '0;
                ker_cnt_d = '0;
                i_d       = '0;
                j_d       = '0;
                r_d       = '0;
                c_d       = '0;
                clr       = 1'b1;
                state_d   = LOAD;
            end
            LOAD: begin
                img_cnt_d = img_hs ? img_cnt_q + IW'(1) : img_cnt_q;
                ker_cnt_d = ker_hs ? ker_cnt_q + KW'(1) : ker_cnt_q;
                state_d   = (img_cnt_q == NI_L && ker_cnt_q == NK_L) ? CALC : LOAD;
            end
            CALC: begin
                en      = 1'b1;
                j_d     = j_q == K_L ? '0 : j_q + CW'(1);
                i_d     = j_q != K_L ? i_q : i_q == K_L ? '0 : i_q + CW'(1);
                state_d = (i_q == K_L && j_q == K_L) ? HOLD : CALC;
            end
            HOLD: if (bus.out_ready) begin
                clr     = 1'b1;
                c_d     = c_q == O_L ? '0 : c_q + OW'(1);
                r_d     = c_q == O_L ? r_q + OW'(1) : r_q;
                done_d  = last;
                state_d = last ? IDLE : CALC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q   <= IDLE;
            img_cnt_q <= '0;
            ker_cnt_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            r_q       <= '0;
            c_q       <= '0;
            flip_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            img_cnt_q <= img_cnt_d;
            ker_cnt_q <= ker_cnt_d;
            i_q       <= i_d;
            j_q       <= j_d;
            r_q       <= r_d;
            c_q       <= c_d;
            flip_q    <= flip_d;
            done_q    <= done_d;
        end

    conv_mac #(.DW(DW), .AW(AW), .FRAC(FRAC)) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (en),
        .a_i   (pix),
        .b_i   (kv),
        .y_o   (y)
    );
endmodule

// File: tb/tb_conv2d_stream_engine.sv
// tb_conv2d_stream_engine: randomized frames against a padded-array reference model, scoreboard-checked.
module tb_conv2d_stream_engine;
    localparam int DW = 16, IMG = 4, KER = 3, PAD = 1, FRAC = 0;
    localparam int OUT = IMG + 2 * PAD - KER + 1, NI = IMG * IMG, NK = KER * KER, PW = IMG + 2 * PAD;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    conv2d_stream_engine_if #(.DW(DW)) bus ();
    conv2d_stream_engine #(.DW(DW), .IMG(IMG), .KER(KER), .PAD(PAD), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 l;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    int                   total = 0, bad = 0, rdy_mode = 0, hold_cnt = 0;
    longint               cyc = 0, prev_hs = -1;
    logic                 held_v = 1'b0;
    logic signed [DW-1:0] held_d;
    int                   img_a[NI];
    int                   ker_a[NK];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: explicit zero-padded image and pre-rotated kernel, plain sliding window.
    function automatic void model(input bit fl);
        longint p[PW][PW];
        longint k[KER][KER];
        longint s, mx, mn;
        exp_t   e;
        mx = (longint'(1) << (DW - 1)) - 1;
        mn = -(longint'(1) << (DW - 1));
        foreach (p[y, x]) p[y][x] = 0;
        for (int y = 0; y < IMG; y++)
            for (int x = 0; x < IMG; x++) p[y+PAD][x+PAD] = img_a[y*IMG+x];
        for (int i = 0; i < KER; i++)
            for (int j = 0; j < KER; j++)
                k[i][j] = fl ? ker_a[(KER-1-i)*KER + KER-1-j] : ker_a[i*KER+j];
        for (int r = 0; r < OUT; r++)
            for (int c = 0; c < OUT; c++) begin
                s = 0;
                for (int i = 0; i < KER; i++)
                    for (int j = 0; j < KER; j++) s += p[r+i][c+j] * k[i][j];
                s = s >>> FRAC;
`ifdef CONV_SAT_EN
                if (s > mx) s = mx;
                else if (s < mn) s = mn;
`else
                if (mx < mn) s = 0;
`endif
                e.d = DW'(s);
                e.l = (r == OUT - 1 && c == OUT - 1);
                exp_q.push_back(e);
            end
    endfunction

    task automatic fill(input int kind);
        logic signed [DW-1:0] t;
        for (int n = 0; n < NI; n++) begin
            t = DW'($urandom);
            img_a[n] = kind == 0 ? 1 : kind == 1 ? int'(t) : kind == 2 ? int'($urandom_range(0, 15)) - 8 :
                       kind == 3 ? 32767 : -32768;
        end
        for (int n = 0; n < NK; n++) begin
            t = DW'($urandom);
            ker_a[n] = kind == 0 ? 1 : kind == 1 ? int'(t) : kind == 2 ? int'($urandom_range(0, 15)) - 8 : 32767;
        end
    endtask

    task automatic feed_img();
        int n = 0, g = 0;
        bit hs;
        while (n < NI && g < 1000) begin
            bus.img_valid = ($urandom_range(0, 3) != 0);
            bus.img_data  = DW'(img_a[n]);
            @(negedge clk);
            hs = bus.img_valid && bus.img_ready;
            @(posedge clk);
            #1;
            if (hs) n++;
            g++;
        end
        if (n < NI) begin
            bad++; total++;
            $display("FAIL img_load_timeout: accepted %0d expected %0d", n, NI);
        end
        bus.img_valid = 1'b1;
        @(negedge clk);
        chk("img_ready_drop", bus.img_ready, 0);
        @(posedge clk);
        #1 bus.img_valid = 1'b0;
    endtask

    task automatic feed_ker();
        int n = 0, g = 0;
        bit hs;
        while (n < NK && g < 1000) begin
            bus.ker_valid = ($urandom_range(0, 3) != 0);
            bus.ker_data  = DW'(ker_a[n]);
            @(negedge clk);
            hs = bus.ker_valid && bus.ker_ready;
            @(posedge clk);
            #1;
            if (hs) n++;
            g++;
        end
        if (n < NK) begin
            bad++; total++;
            $display("FAIL ker_load_timeout: accepted %0d expected %0d", n, NK);
        end
        bus.ker_valid = 1'b1;
        @(negedge clk);
        chk("ker_ready_drop", bus.ker_ready, 0);
        @(posedge clk);
        #1 bus.ker_valid = 1'b0;
    endtask

    task automatic start_and_load(input bit fl, input int order);
        bus.start = 1'b1;
        bus.flip  = fl;
        @(posedge clk);
        #1 bus.flip = ~fl;
        @(negedge clk);
        chk("busy_after_start", bus.busy, 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (order == 1) begin
            feed_ker();
            feed_img();
        end else if (order == 2) begin
            feed_img();
            feed_ker();
        end else
            fork
                feed_img();
                feed_ker();
            join
    endtask

    task automatic run_frame(input bit fl, input int order, input int rmode);
        int g = 0;
        model(fl);
        rdy_mode = rmode;
        prev_hs  = -1;
        start_and_load(fl, order);
        while (!bus.done && g < 5000) begin
            @(negedge clk);
            g++;
        end
        if (!bus.done) begin
            bad++; total++;
            $display("FAIL done_timeout: done=%0b after %0d cycles expected 1", bus.done, g);
            exp_q.delete();
        end
        chk("queue_empty_at_done", exp_q.size(), 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("idle_after_done", bus.busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) bus.out_ready = 1'b1;
            else if (rdy_mode == 1) bus.out_ready = $urandom_range(0, 1) == 1;
            else if (bus.out_valid && hold_cnt < 5) begin
                bus.out_ready = 1'b0;
                hold_cnt++;
            end else begin
                bus.out_ready = 1'b1;
                hold_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (held_v) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", bus.out_data, held_d);
                end
                held_v = bus.out_valid && !bus.out_ready;
                held_d = bus.out_data;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        bad++; total++;
                        $display("FAIL unexpected_output: got %0d expected none", bus.out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("out_data", bus.out_data, mon_e.d);
                        chk("out_last", bus.out_last, mon_e.l);
                    end
                    if (rdy_mode == 0 && prev_hs >= 0) chk("output_gap", cyc - prev_hs, NK + 1);
                    prev_hs = bus.out_last ? -1 : cyc;
                end
            end else held_v = 1'b0;
        end
    end

    initial begin
        bus.start = 1'b0; bus.flip = 1'b0;
        bus.img_valid = 1'b0; bus.img_data = '0;
        bus.ker_valid = 1'b0; bus.ker_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_img_ready", bus.img_ready, 0);
        chk("rst_ker_ready", bus.ker_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill(0); run_frame(1'b0, 0, 0);
        fill(1); run_frame(1'b1, 1, 1);
        run_frame(1'b1, 2, 2);
        for (int f = 0; f < 3; f++) begin
            fill(f == 1 ? 2 : 1);
            run_frame(f[0], 0, f == 2 ? 0 : 1);
        end
        fill(3); run_frame(1'b0, 0, 0);
        fill(4); run_frame(1'b1, 1, 1);
        fill(1);
        rdy_mode = 0;
        start_and_load(1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_busy", bus.busy, 0);
        chk("midreset_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fill(2); run_frame(1'b1, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parameterised 2D convolution/correlation engine for the CNN datapath, generalising the fixed 16x16 padded conv block.
- Loads an IMG x IMG feature map and a KER x KER kernel over valid/ready streams, then computes every output with one sequential MAC.
- Zero padding is implicit. A per-frame mode selects correlation (forward pass) or flipped-kernel convolution (backward/gradient pass).
- Outputs are streamed with backpressure and a last flag.

Parameters:
- DW, 16: signed data width of image, kernel and output samples.
- IMG, 16: image side length.
- KER, 3: kernel side length; must satisfy KER <= IMG+2*PAD, otherwise elaboration error.
- PAD, 1: zero-padding width on each border.
- FRAC, 0: arithmetic right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin frame; honoured only in IDLE
- flip  in  1  sampled with start: 0 = correlation, 1 = kernel rotated 180 degrees
- img_valid  in  1  image sample valid
- img_ready  out  1  engine accepts image sample
- img_data  in  DW  signed image sample, row-major
- ker_valid  in  1  kernel sample valid
- ker_ready  out  1  engine accepts kernel sample
- ker_data  in  DW  signed kernel sample, row-major
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts output
- out_data  out  DW  signed output sample, row-major
- out_last  out  1  marks the final output of the frame
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last output handshake

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. Reset forces the FSM to IDLE and clears all counters. Outputs during reset: img_ready=0, ker_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. Storage arrays are not reset.
- OUT = IMG+2*PAD-KER+1. Accumulator width AW = 2*DW+clog2(KER*KER).
- FSM states: IDLE, LOAD, CALC, HOLD.
- IDLE: on start, latch flip and go to LOAD.
- LOAD:
  - img_ready is high while img_cnt < IMG*IMG; ker_ready is high while ker_cnt < KER*KER.
  - The two streams are independent and may complete in any order, including simultaneously.
  - Each handshake writes to the next row-major slot.
  - Go to CALC on the cycle after both counts are full.
- CALC:
  - One MAC per cycle over (i,j), i and j in 0..KER-1.
  - Product term: pixel(r+i-PAD, c+j-PAD) * k(i,j), where k(i,j) = ker[i][j] if flip=0, ker[KER-1-i][KER-1-j] if flip=1.
  - Out-of-range pixel coordinates contribute 0; no padded storage exists.
  - After KER*KER MACs, go to HOLD.
- HOLD:
  - out_valid=1; out_data = (acc >>> FRAC), truncated to the low DW bits.
  - out_data and out_last stay stable until out_ready.
  - On handshake, clear acc and advance (r,c). Go to CALC for the next output; after output OUT*OUT, go to IDLE with done=1 for one cycle.
- Latency per output: KER*KER cycles in CALC, then out_valid asserted on the next cycle. Zero-stall throughput is one output per KER*KER+1 cycles.
- Boundary conditions:
  - Handshakes cannot occur while ready is low.
  - start is ignored while busy.
  - A new start is accepted in IDLE on the cycle after done.
  - Reset asserted mid-frame returns to IDLE immediately; partial outputs are discarded.
  - out_ready held high continuously produces no bubbles beyond the CALC cycles.

Optional Feature:
- CONV_SAT_EN defined: the shifted accumulator is saturated to the signed DW range, i.e. [-2^(DW-1), 2^(DW-1)-1].
- CONV_SAT_EN undefined: plain two's-complement truncation (wrap).

Decomposition:
- Package conv_pkg contents:
  - state enum {IDLE, LOAD, CALC, HOLD};
  - clog2 function;
  - out_size(IMG,KER,PAD) function;
  - acc_width(DW,KER) function.
- One sub-module, conv_mac:
  - signed multiply-accumulate with synchronous clear and enable;
  - output stage implementing shift plus saturate/truncate, including the CONV_SAT_EN logic.

Test Plan:
- IMG=4, KER=3, PAD=1, all-ones image and kernel, flip=0 -> 16 outputs: corners 4, edges 6, inner 9; out_last on the 16th; done pulses once.
- IMG=3, KER=3, PAD=0, image 1..9, kernel 1..9 -> flip=0 gives single output 285; flip=1 gives 165; out_last=1 on that output.
- Kernel stream fully loaded before image stream begins, and the reverse -> identical results; img_ready drops after 16 accepts, ker_ready after 9.
- out_ready held low for 5 cycles in HOLD -> out_valid stays 1 and out_data is unchanged; no outputs are lost or duplicated.
- IMG=3, KER=3, PAD=0, all samples 0x7FFF -> output 0x7FFF with CONV_SAT_EN defined, 0x0009 without it.
- rst_n pulsed low mid-CALC -> busy=0 and out_valid=0 immediately; a subsequent start plus full reload produces correct results.
